// File: rtl/fpu_shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_shift_pkg
// Description : Shared constants and types for the FPU fraction-shifter arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_shift_pkg;

  localparam int FRAC_W     = 26;
  localparam int SHAMT_W    = 8;
  localparam int TAG_W      = 4;
  localparam int LOCK_CNT_W = 4;

  localparam logic REQ_ALIGN = 1'b0;
  localparam logic REQ_F2I   = 1'b1;

  localparam logic [LOCK_CNT_W-1:0] LOCK_CNT_MAX = '1;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

endpackage
`default_nettype wire

// File: rtl/fpu_shift_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fpu_shift_arbiter_if
// Description : Two-requester shift request bus plus buffered response bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface fpu_shift_arbiter_if;
  import fpu_shift_pkg::*;

  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [1:0]           req_lock;
  logic [2*FRAC_W-1:0]  req_fraction;
  logic [2*SHAMT_W-1:0] req_shamt;
  logic [2*TAG_W-1:0]   req_tag;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_owner;
  logic [FRAC_W-1:0]    rsp_result;
  logic                 rsp_sticky;
  logic [TAG_W-1:0]     rsp_tag;

  // Requester/consumer side.
  modport master (
    output req_valid, req_lock, req_fraction, req_shamt, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_owner, rsp_result, rsp_sticky, rsp_tag
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_lock, req_fraction, req_shamt, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_owner, rsp_result, rsp_sticky, rsp_tag
  );

endinterface
`default_nettype wire

// File: rtl/fpu_sticky_gen.sv
`default_nettype none
// ============================================================================
// Module      : fpu_sticky_gen
// Description : OR of all fraction bits that a right shift by shamt discards.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_sticky_gen
  import fpu_shift_pkg::*;
#(
  parameter int DATA_W = FRAC_W,
  parameter int AMT_W  = SHAMT_W
) (
  input  logic [DATA_W-1:0] i_fraction,
  input  logic [AMT_W-1:0]  i_shamt,
  output logic              o_sticky
);

  logic [DATA_W-1:0] w_mask;

  // Bit b falls off the end whenever shamt exceeds b; saturates naturally.
  for (genvar b = 0; b < DATA_W; b++) begin : g_mask
    assign w_mask[b] = (32'(i_shamt) > 32'(b));
  end

  assign o_sticky = |(i_fraction & w_mask);

endmodule
`default_nettype wire

// File: rtl/right_shift.sv
`default_nettype none
// ============================================================================
// Module      : right_shift
// Description : Combinational logarithmic right shifter, zero-filled from MSB.
// Revision    : 1.0 - initial release
// ============================================================================
module right_shift #(
  parameter int WIDTH = 26,
  parameter int AMT_W = 8
) (
  input  logic [WIDTH-1:0] i_din,
  input  logic [AMT_W-1:0] i_shamt,
  output logic [WIDTH-1:0] o_dout
);

  localparam int STAGES = $clog2(WIDTH);

  logic [WIDTH-1:0] w_stage [STAGES+1];
  logic             w_overflow;

  assign w_stage[0] = i_din;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    assign w_stage[s+1] = i_shamt[s] ? (w_stage[s] >> (1 << s)) : w_stage[s];
  end

  // Amounts of WIDTH and beyond empty the word regardless of the low stages.
  assign w_overflow = (32'(i_shamt) >= 32'(WIDTH));
  assign o_dout     = w_overflow ? '0 : w_stage[STAGES];

endmodule
`default_nettype wire

// File: rtl/fpu_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpu_shift_arbiter
// Description : Round-robin share of one fraction shifter between FP align and
//               float-to-int, with grant lock and a one-entry result buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_shift_arbiter
  import fpu_shift_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  fpu_shift_arbiter_if.slave  bus
);

  buf_state_t              r_state;
  buf_state_t              w_state_next;

  logic                    r_last_grant;
  logic                    r_lock_active;
  logic                    r_lock_owner;
  logic [LOCK_CNT_W-1:0]   r_lock_cnt;
  logic                    w_lock_expire;

  logic                    w_can_accept;
  logic [1:0]              w_grant;
  logic [1:0]              w_accept;
  logic                    w_any_accept;
  logic                    w_sel;
  logic                    w_sel_lock;

  logic [FRAC_W-1:0]       w_fraction;
  logic [SHAMT_W-1:0]      w_shamt;
  logic [TAG_W-1:0]        w_tag;
  logic [FRAC_W-1:0]       w_shifted;
  logic                    w_sticky;

  logic [FRAC_W-1:0]       r_result;
  logic                    r_sticky;
  logic [TAG_W-1:0]        r_tag;
  logic                    r_owner;

  // ---------------------------------------------------------------- arbiter
  assign w_can_accept = (r_state == EMPTY) | bus.rsp_ready;

  // A requester's grant looks only at the other side's valid, never its own.
  always_comb begin
    w_grant = 2'b00;
    if (r_lock_active) begin
      w_grant[r_lock_owner] = 1'b1;
    end else begin
      w_grant[0] = ~bus.req_valid[1] | r_last_grant;
      w_grant[1] = ~bus.req_valid[0] | ~r_last_grant;
    end
  end

  assign bus.req_ready = {2{w_can_accept}} & w_grant;
  assign w_accept      = bus.req_valid & bus.req_ready;
  assign w_any_accept  = |w_accept;
  assign w_sel         = w_accept[REQ_F2I] ? REQ_F2I : REQ_ALIGN;
  assign w_sel_lock    = w_sel ? bus.req_lock[1] : bus.req_lock[0];

  // ---------------------------------------------------------------- datapath
  assign w_fraction = w_sel ? bus.req_fraction[2*FRAC_W-1:FRAC_W]
                            : bus.req_fraction[FRAC_W-1:0];
  assign w_shamt    = w_sel ? bus.req_shamt[2*SHAMT_W-1:SHAMT_W]
                            : bus.req_shamt[SHAMT_W-1:0];
  assign w_tag      = w_sel ? bus.req_tag[2*TAG_W-1:TAG_W]
                            : bus.req_tag[TAG_W-1:0];

  right_shift #(
    .WIDTH (FRAC_W),
    .AMT_W (SHAMT_W)
  ) u_right_shift (
    .i_din   (w_fraction),
    .i_shamt (w_shamt),
    .o_dout  (w_shifted)
  );

  fpu_sticky_gen #(
    .DATA_W (FRAC_W),
    .AMT_W  (SHAMT_W)
  ) u_sticky_gen (
    .i_fraction (w_fraction),
    .i_shamt    (w_shamt),
    .o_sticky   (w_sticky)
  );

  // ---------------------------------------------------------------- lock
  assign w_lock_expire = r_lock_active & (r_lock_cnt == LOCK_CNT_MAX);

  // Expiry wins over a re-lock so the non-owner always gets a turn.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_last_grant  <= 1'b1;
      r_lock_active <= 1'b0;
      r_lock_owner  <= 1'b0;
      r_lock_cnt    <= '0;
    end else begin
      if (w_any_accept) begin
        r_last_grant <= w_sel;
      end
      if (w_lock_expire) begin
        r_lock_active <= 1'b0;
        r_lock_cnt    <= '0;
      end else if (w_any_accept && w_sel_lock && !r_lock_active) begin
        r_lock_active <= 1'b1;
        r_lock_owner  <= w_sel;
        r_lock_cnt    <= '0;
      end else if (w_any_accept && !w_sel_lock && r_lock_active) begin
        r_lock_active <= 1'b0;
        r_lock_cnt    <= '0;
      end else if (r_lock_active) begin
        r_lock_cnt    <= r_lock_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- buffer
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      EMPTY: begin
        if (w_any_accept) w_state_next = FULL;
      end
      FULL: begin
        if (w_any_accept)        w_state_next = FULL;
        else if (bus.rsp_ready)  w_state_next = EMPTY;
      end
      default: w_state_next = EMPTY;
    endcase
  end

  // Loads only on accept, which keeps the outputs frozen under backpressure.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_result <= '0;
      r_sticky <= 1'b0;
      r_tag    <= '0;
      r_owner  <= 1'b0;
    end else if (w_any_accept) begin
      r_result <= w_shifted;
      r_sticky <= w_sticky;
      r_tag    <= w_tag;
      r_owner  <= w_sel;
    end
  end

  assign bus.rsp_valid  = (r_state == FULL);
  assign bus.rsp_owner  = r_owner;
  assign bus.rsp_result = r_result;
  assign bus.rsp_sticky = r_sticky;
  assign bus.rsp_tag    = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_fpu_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_shift_arbiter
// Description : Scoreboard bench for the shared fraction-shifter arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_shift_arbiter;
  import fpu_shift_pkg::*;

  typedef struct packed {
    logic               owner;
    logic [TAG_W-1:0]   tag;
    logic               sticky;
    logic [FRAC_W-1:0]  result;
  } exp_rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_shift_arbiter_if bus ();

  fpu_shift_arbiter dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  exp_rsp_t sb_q [$];

  // Reference model state
  logic m_last;
  logic m_lock_act;
  logic m_lock_own;
  int   m_lock_cnt;
  logic m_full;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_rsp_t model_op(input logic [FRAC_W-1:0] f, input logic [SHAMT_W-1:0] s,
                                        input logic [TAG_W-1:0] t, input logic o);
    exp_rsp_t r;
    logic [FRAC_W-1:0] m;
    r.owner = o;
    r.tag   = t;
    if (s == 0) begin
      r.result = f;
      r.sticky = 1'b0;
    end else if (s >= FRAC_W) begin
      r.result = '0;
      r.sticky = |f;
    end else begin
      r.result = f >> s;
      m        = (FRAC_W'(1) << s) - FRAC_W'(1);
      r.sticky = |(f & m);
    end
    return r;
  endfunction

  function automatic logic [SHAMT_W-1:0] rand_sh();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return SHAMT_W'($urandom_range(1, 25));
      2:       return SHAMT_W'($urandom_range(26, 31));
      default: return SHAMT_W'($urandom());
    endcase
  endfunction

  task automatic model_reset();
    m_last     = 1'b1;
    m_lock_act = 1'b0;
    m_lock_own = 1'b0;
    m_lock_cnt = 0;
    m_full     = 1'b0;
    sb_q.delete();
  endtask

  task automatic idle_inputs();
    bus.req_valid    = '0;
    bus.req_lock     = '0;
    bus.req_fraction = '0;
    bus.req_shamt    = '0;
    bus.req_tag      = '0;
    bus.rsp_ready    = 1'b0;
  endtask

  // One clock: drive, check against the model, then advance the model.
  task automatic cycle(input logic [1:0] v, input logic [1:0] lk,
                       input logic [FRAC_W-1:0] f0, input logic [FRAC_W-1:0] f1,
                       input logic [SHAMT_W-1:0] s0, input logic [SHAMT_W-1:0] s1,
                       input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1,
                       input logic rdy);
    logic [1:0] g;
    logic [1:0] rdy_exp;
    logic [1:0] acc;
    logic       idx;
    @(negedge clk);
    bus.req_valid    = v;
    bus.req_lock     = lk;
    bus.req_fraction = {f1, f0};
    bus.req_shamt    = {s1, s0};
    bus.req_tag      = {t1, t0};
    bus.rsp_ready    = rdy;
    #1;
    if (m_lock_act) begin
      g = m_lock_own ? 2'b10 : 2'b01;
    end else begin
      g[0] = !v[1] || (m_last != 1'b0);
      g[1] = !v[0] || (m_last != 1'b1);
    end
    rdy_exp = (!m_full || rdy) ? g : 2'b00;
    check_val("req_ready", 32'(bus.req_ready), 32'(rdy_exp));
    check_val("rsp_valid", 32'(bus.rsp_valid), 32'(m_full));
    if (m_full && sb_q.size() > 0) begin
      check_val("rsp_owner",  32'(bus.rsp_owner),  32'(sb_q[0].owner));
      check_val("rsp_result", 32'(bus.rsp_result), 32'(sb_q[0].result));
      check_val("rsp_sticky", 32'(bus.rsp_sticky), 32'(sb_q[0].sticky));
      check_val("rsp_tag",    32'(bus.rsp_tag),    32'(sb_q[0].tag));
      if (rdy) void'(sb_q.pop_front());
    end
    acc = v & rdy_exp;
    idx = acc[1];
    if (acc != 2'b00)
      sb_q.push_back(model_op(idx ? f1 : f0, idx ? s1 : s0, idx ? t1 : t0, idx));
    if (m_lock_act && m_lock_cnt == 15) begin
      m_lock_act = 1'b0;
      m_lock_cnt = 0;
    end else if (acc != 2'b00 && lk[idx] && !m_lock_act) begin
      m_lock_act = 1'b1;
      m_lock_own = idx;
      m_lock_cnt = 0;
    end else if (acc != 2'b00 && !lk[idx] && m_lock_act) begin
      m_lock_act = 1'b0;
      m_lock_cnt = 0;
    end else if (m_lock_act) begin
      m_lock_cnt++;
    end
    if (acc != 2'b00) m_last = idx;
    m_full = (acc != 2'b00) ? 1'b1 : (rdy ? 1'b0 : m_full);
  endtask

  task automatic op0(input logic [FRAC_W-1:0] f, input logic [SHAMT_W-1:0] s, input logic [TAG_W-1:0] t);
    cycle(2'b01, 2'b00, f, '0, s, '0, t, '0, 1'b1);
  endtask

  task automatic op1(input logic [FRAC_W-1:0] f, input logic [SHAMT_W-1:0] s, input logic [TAG_W-1:0] t);
    cycle(2'b10, 2'b00, '0, f, '0, s, '0, t, 1'b1);
  endtask

  task automatic both(input logic [1:0] lk, input logic rdy);
    cycle(2'b11, lk, FRAC_W'($urandom()), FRAC_W'($urandom()), rand_sh(), rand_sh(),
          TAG_W'($urandom()), TAG_W'($urandom()), rdy);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(2'b00, 2'b00, '0, '0, '0, '0, '0, '0, 1'b1);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_valid",  32'(bus.rsp_valid),  32'd0);
    check_val("rst_owner",  32'(bus.rsp_owner),  32'd0);
    check_val("rst_result", 32'(bus.rsp_result), 32'd0);
    check_val("rst_sticky", 32'(bus.rsp_sticky), 32'd0);
    check_val("rst_tag",    32'(bus.rsp_tag),    32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Contention straight out of reset: 0,1,0,1,...
    for (int i = 0; i < 8; i++) both(2'b00, 1'b1);
    drain(2);

    // Single op with explicit one-cycle latency check.
    op0(26'h3FFFFFF, 8'd4, 4'd5);
    @(posedge clk);
    #1;
    check_val("single_valid",  32'(bus.rsp_valid),  32'd1);
    check_val("single_result", 32'(bus.rsp_result), 32'h03FFFFF);
    check_val("single_sticky", 32'(bus.rsp_sticky), 32'd1);
    check_val("single_owner",  32'(bus.rsp_owner),  32'd0);
    check_val("single_tag",    32'(bus.rsp_tag),    32'd5);
    drain(1);

    // Shift boundaries.
    op0(26'h1234567, 8'd0,   4'd1);
    op1(26'h0000001, 8'd26,  4'd2);
    op0(26'h0000001, 8'd200, 4'd3);
    op1(26'h2000000, 8'd25,  4'd4);
    op0(26'h0000000, 8'd255, 4'd6);
    op1(26'h3FFFFFF, 8'd1,   4'd7);
    drain(1);

    // Backpressure: result held for 5 cycles, then drain + accept together.
    op0(26'h0ABCDEF, 8'd3, 4'd9);
    for (int i = 0; i < 5; i++) both(2'b00, 1'b0);
    cycle(2'b10, 2'b00, '0, 26'h1555555, '0, 8'd2, '0, 4'hA, 1'b1);
    drain(2);

    // Lock: req1 holds for 3 ops while req0 waits, then releases.
    op0(26'h00000FF, 8'd4, 4'h1);
    for (int i = 0; i < 3; i++) both(2'b10, 1'b1);
    both(2'b00, 1'b1);
    both(2'b00, 1'b1);
    drain(1);

    // Lock held past the 16-cycle limit forces a release to req0.
    for (int i = 0; i < 20; i++) both(2'b10, 1'b1);
    both(2'b00, 1'b1);
    drain(2);

    // Randomised mix of valids, locks and backpressure.
    for (int i = 0; i < 80; i++) begin
      logic [1:0] v;
      logic [1:0] lk;
      logic       rdy;
      v   = 2'($urandom_range(0, 3));
      lk  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rdy = ($urandom_range(0, 3) != 0);
      cycle(v, lk, FRAC_W'($urandom()), FRAC_W'($urandom()), rand_sh(), rand_sh(),
            TAG_W'($urandom()), TAG_W'($urandom()), rdy);
    end
    drain(3);

    // Reset while a result is buffered: immediate clear, no stale response.
    op1(26'h3000000, 8'd5, 4'hC);
    @(negedge clk);
    #1;
    check_val("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
    idle_inputs();
    #1;
    rst = 1'b1;
    #1;
    check_val("rst_async_valid", 32'(bus.rsp_valid), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drain(2);
    for (int i = 0; i < 4; i++) both(2'b00, 1'b1);
    drain(2);

    check_val("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
